// File: rtl/sram_uart_tx_if.sv
// Bus bundle between a transfer requester/SRAM and the SRAM-to-UART transmitter.
interface sram_uart_tx_if #(
    parameter int unsigned AW = 18
);
    logic          Start;
    logic [AW-1:0] Start_address;
    logic [AW-1:0] Word_count;
    logic [AW-1:0] SRAM_address;
    logic          SRAM_re;
    logic [15:0]   SRAM_read_data;
    logic          UART_TX_O;
    logic          Busy;
    logic          Done;

    // Requester / memory side
    modport master (
        output Start, Start_address, Word_count, SRAM_read_data,
        input  SRAM_address, SRAM_re, UART_TX_O, Busy, Done
    );

    // Transmitter side
    modport slave (
        input  Start, Start_address, Word_count, SRAM_read_data,
        output SRAM_address, SRAM_re, UART_TX_O, Busy, Done
    );
endinterface

// File: rtl/sram_uart_tx.sv
// Reads 16-bit words from a 2-cycle-latency SRAM and sends each as two
// 8N1 UART frames (high byte first), all outputs registered.
module sram_uart_tx #(
    parameter int unsigned C_M_AXI_ACLK_FREQ_HZ = 100000000,
    parameter int unsigned C_BAUDRATE           = 9600,
    parameter int unsigned MEMORY_ADDR_WIDTH    = 18,
    parameter int unsigned MEMORY_DATA_WIDTH    = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    sram_uart_tx_if.slave bus
);
    localparam int unsigned AW           = MEMORY_ADDR_WIDTH;
    localparam int unsigned CLKS_PER_BIT = C_M_AXI_ACLK_FREQ_HZ / C_BAUDRATE;
    localparam int unsigned BW           = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SHIFT, NEXT} state_t;

    state_t                       state;
    logic [AW-1:0]                sram_address;
    logic                         sram_re;
    logic                         tx;
    logic                         busy;
    logic                         done;
    logic [MEMORY_DATA_WIDTH-1:0] word;
    logic [AW-1:0]                words_left;
    logic [BW-1:0]                baud;
    logic [3:0]                   bit_cnt;   // 0 start, 1..8 data, 9 stop
    logic                         low_byte;
    logic                         wait_cnt;
    logic [7:0]                   cur_byte;

    assign bus.SRAM_address = sram_address;
    assign bus.SRAM_re      = sram_re;
    assign bus.UART_TX_O    = tx;
    assign bus.Busy         = busy;
    assign bus.Done         = done;

    // Byte currently being serialised
    always_comb begin
        cur_byte = word[15:8];
        if (low_byte)
            cur_byte = word[7:0];
    end

    // Transfer sequencer, baud timing and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            sram_address <= '0;
            sram_re      <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            word         <= '0;
            words_left   <= '0;
            baud         <= '0;
            bit_cnt      <= '0;
            low_byte     <= 1'b0;
            wait_cnt     <= 1'b0;
        end else begin
            done    <= 1'b0;
            sram_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start && bus.Word_count != '0) begin
                        sram_address <= bus.Start_address;
                        words_left   <= bus.Word_count;
                        sram_re      <= 1'b1;
                        busy         <= 1'b1;
                        state        <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt) begin
                        word     <= bus.SRAM_read_data;
                        tx       <= 1'b0;
                        bit_cnt  <= '0;
                        low_byte <= 1'b0;
                        baud     <= BAUD_RELOAD;
                        state    <= SHIFT;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (baud != '0) begin
                        baud <= baud - BW'(1);
                        // When more words follow, the final stop-bit cycle is
                        // spent in NEXT so the following READ lands right after
                        // the stop bit, giving exactly READ+2xWAIT idle cycles.
                        if (low_byte && bit_cnt == 4'd9 && baud == BW'(1) &&
                            words_left != AW'(1)) begin
                            words_left <= words_left - AW'(1);
                            state      <= NEXT;
                        end
                    end else if (bit_cnt == 4'd9) begin
                        if (!low_byte) begin
                            low_byte <= 1'b1;
                            bit_cnt  <= '0;
                            tx       <= 1'b0;
                            baud     <= BAUD_RELOAD;
                        end else begin
                            words_left <= words_left - AW'(1);
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        baud    <= BAUD_RELOAD;
                        if (bit_cnt == 4'd8)
                            tx <= 1'b1;
                        else
                            tx <= cur_byte[bit_cnt[2:0]];
                    end
                end
                NEXT: begin
                    sram_address <= sram_address + AW'(1);
                    sram_re      <= 1'b1;
                    state        <= READ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_uart_tx.md
SRAM_UART_TX -- requirements
Module: sram_uart_tx

Interface
REQ-001 SHALL have parameter C_M_AXI_ACLK_FREQ_HZ, default 100000000, the clock frequency in Hz.
REQ-002 SHALL have parameter C_BAUDRATE, default 9600, the serial bit rate.
REQ-003 SHALL have parameter MEMORY_ADDR_WIDTH (AW), default 18, the embedded memory address width.
REQ-004 SHALL have parameter MEMORY_DATA_WIDTH, default 16, the memory word width; only the value 16 is supported.
REQ-005 SHALL have a derived constant CLKS_PER_BIT = C_M_AXI_ACLK_FREQ_HZ / C_BAUDRATE (integer division, must be >= 2).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Clock  in  1  sole clock; all logic on its rising edge.
REQ-008 Reset  in  1  synchronous, active-high reset.
REQ-009 Start  in  1  single-cycle request to begin a transfer.
REQ-010 Start_address  in  AW  first memory word to send.
REQ-011 Word_count  in  AW  number of 16-bit words to send.
REQ-012 SRAM_address  out  AW  memory read address.
REQ-013 SRAM_re  out  1  read strobe, one cycle per word.
REQ-014 SRAM_read_data  in  16  read data, valid exactly 2 cycles after the cycle SRAM_re=1.
REQ-015 UART_TX_O  out  1  serial output; idle level is 1.
REQ-016 Busy  out  1  high while a transfer is in progress.
REQ-017 Done  out  1  one-cycle pulse when a transfer completes.

Function
REQ-018 SHALL implement states IDLE, READ, WAIT, SHIFT and NEXT.
REQ-019 IDLE: Start=1 and Word_count!=0 -> latch Start_address and Word_count, go to READ; Start with Word_count=0 is ignored (no Busy, no Done).
REQ-020 Start is ignored in every state except IDLE.
REQ-021 READ (1 cycle): SRAM_re=1, SRAM_address=current address, Busy=1 -> WAIT.
REQ-022 WAIT (2 cycles): on the second cycle, latch SRAM_read_data into the word register -> SHIFT.
REQ-023 Timing reference: Start sampled at t0 -> READ at t1 -> data latched at t3 -> first start bit driven at t4.
REQ-024 SHIFT sends two frames back-to-back with no idle gap between them: byte [15:8] first, then byte [7:0].
REQ-025 Each frame SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; no parity.
REQ-026 Each bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a counter that reloads at every bit boundary.
REQ-027 After the low byte's stop bit: decrement the remaining count; if nonzero, go to NEXT; if zero, go to IDLE with Done=1 for one cycle and Busy=0 on that same cycle.
REQ-028 NEXT: increment the address modulo 2^AW (wraps from all-ones to 0) -> READ; UART_TX_O stays 1.
REQ-029 Between consecutive words there SHALL be exactly 3 idle-high cycles (READ plus 2 WAIT) between one stop bit and the next start bit.
REQ-030 UART_TX_O SHALL be registered (glitch-free) and equal 1 in every state except during start and data bits.
REQ-031 Busy SHALL be 1 from READ of the first word through the last stop-bit cycle.
REQ-032 SRAM_address SHALL hold its last value when not in READ.

Reset
REQ-033 Reset=1 SHALL force, on the next edge: state IDLE, UART_TX_O=1, Busy=0, Done=0, SRAM_re=0, SRAM_address=0, and bit, baud and word counters cleared.
REQ-034 Reset has priority over Start on the same cycle.
REQ-035 Reset mid-frame SHALL abort the transfer; no Done is produced and the partial frame is truncated to idle-high.

Verification (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10; AW=18)
REQ-036 Reset 2 cycles -> UART_TX_O=1, Busy=0, Done=0, SRAM_address=0.
REQ-037 mem[0x00010]=0xA55A, Start_address=0x00010, Word_count=1, Start at t0 -> SRAM_re at t1 with address 0x00010; start bit at t4; serial bits 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1, each 10 cycles; Done=1 at t204 only; Busy high t1..t203.
REQ-038 Start_address=0x3FFFF, Word_count=2 -> reads issued at 0x3FFFF then 0x00000; exactly 3 idle-high cycles between words; a single Done pulse.
REQ-039 Start during a transfer, and Start with Word_count=0 while idle -> no change in state, addresses, TX or Done.
REQ-040 Reset asserted during data bit 3 of the first byte -> next cycle UART_TX_O=1, Busy=0, no Done; a following Start transfers normally.
REQ-041 Start and Reset in the same cycle -> remains IDLE, SRAM_re never asserted.
